rib_mbox: RTL and testbench

RIB_MBOX -- requirements
Module: rib_mbox

---
 rtl/rib_mbox_pkg.sv | 35 +++
 rtl/rib_mbox_fifo.sv | 69 ++++++
 rtl/rib_mbox.sv | 258 +++++++++++++++++++++++++
 tb/tb_rib_mbox.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_mbox_pkg.sv
// Shared register map, STATUS/CTRL bit positions and access FSM encodings for rib_mbox.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rib_mbox_pkg;

    // Register offsets, decoded from addr_i[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // FIFO occupancy width: holds 0..16
    localparam int CNT_W = 5;

    // STATUS layout
    localparam int ST_RX_CNT_LSB = 0;
    localparam int ST_TX_CNT_LSB = 5;
    localparam int ST_RX_EMPTY   = 10;
    localparam int ST_TX_FULL    = 11;
    localparam int ST_UNDERFLOW  = 12;

    // CTRL layout
    localparam int CTRL_FLUSH  = 0;
    localparam int CTRL_IRQ_EN = 1;

    // Wait-state counter width: holds 0..7
    localparam int WCNT_W = 3;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_WAIT = 2'd1,
        FSM_DONE = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/rib_mbox_fifo.sv
// Synchronous word FIFO with flush; head word is visible on rdata without a pop.
// Latency: push visible at the head one cycle after the write edge when empty.
// Backpressure: push ignored when full, pop ignored when empty; flush beats both.
// Ports: clk/rst (async active-low), push/wdata, pop, flush, rdata (head), count, empty, full.
module rib_mbox_fifo
    import rib_mbox_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rib_mbox.sv
// RIB-bus mailbox: DATA/STATUS/CTRL registers over a TX FIFO (bus->stream) and RX FIFO (stream->bus).
// Latency: WAIT_CYCLES=0 completes in the request cycle; otherwise hold_o spans max(2, WAIT_CYCLES) cycles.
// Backpressure: hold_o stalls the master during wait states and while a DATA write meets a full TX FIFO.
// Ports: clk, rst (async active-low); RIB req_i/we_i/addr_i/data_i/data_o/hold_o;
//        TX stream tx_data_o/tx_valid_o/tx_ready_i; RX stream rx_data_i/rx_valid_i/rx_ready_o; irq_o.
// Option: define RIB_MBOX_IRQ_EN to enable the CTRL.irq_en bit and a registered irq_o.
module rib_mbox #(
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hold_o,
    output logic [31:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    input  logic [31:0] rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        irq_o
);
    import rib_mbox_pkg::*;

    // The request cycle counts as the first wait state, so the counter holds the remainder.
    localparam logic [WCNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WCNT_W'(WAIT_CYCLES - 1) : '0;

    fsm_state_t        state_q;
    fsm_state_t        state_d;
    logic [WCNT_W-1:0] cnt_q;
    logic [WCNT_W-1:0] cnt_d;
    logic [WCNT_W-1:0] cnt_dec;

    logic [1:0]        reg_sel;
    logic              stall;
    logic              hold;
    logic              commit_raw;
    logic              commit;

    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [CNT_W-1:0]  tx_count;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [CNT_W-1:0]  rx_count;
    logic [31:0]       rx_head;

    logic              ctrl_wr;
    logic              flush;
    logic              uf_set;
    logic              underflow;
    logic              irq_en;
    logic [31:0]       status;
    logic [31:0]       rd_word;

    logic              unused_addr;
    assign unused_addr = ^{addr_i[31:4], addr_i[1:0]};

    assign reg_sel = addr_i[3:2];
    // A DATA write may only commit while the TX FIFO has room.
    assign stall   = we_i & (reg_sel == REG_DATA) & tx_full;
    assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - WCNT_W'(1);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FSM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FSM_IDLE: begin
                if (req_i) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = FSM_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else if (stall) begin
                        state_d = FSM_DONE;
                    end
                end
            end
            FSM_WAIT: begin
                if (!req_i) begin
                    state_d = FSM_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_dec;
                    if (cnt_dec == '0) begin
                        state_d = FSM_DONE;
                    end
                end
            end
            FSM_DONE: begin
                if (!req_i || !stall) begin
                    state_d = FSM_IDLE;
                end
            end
            default: begin
                state_d = FSM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        hold       = 1'b0;
        commit_raw = 1'b0;
        case (state_q)
            FSM_IDLE: begin
                if (req_i) begin
                    if ((WAIT_CYCLES > 0) || stall) begin
                        hold = 1'b1;
                    end else begin
                        commit_raw = 1'b1;
                    end
                end
            end
            FSM_WAIT: begin
                hold = req_i;
            end
            FSM_DONE: begin
                if (req_i) begin
                    if (stall) begin
                        hold = 1'b1;
                    end else begin
                        commit_raw = 1'b1;
                    end
                end
            end
            default: begin
                hold       = 1'b0;
                commit_raw = 1'b0;
            end
        endcase
    end

    // Outputs must be quiet while reset is held, even with req_i high.
    assign commit = commit_raw & rst;
    assign hold_o = hold & rst;

    // ---------------- Access side effects ----------------
    assign tx_push = commit & we_i & (reg_sel == REG_DATA);
    assign rx_pop  = commit & ~we_i & (reg_sel == REG_DATA) & ~rx_empty;
    assign uf_set  = commit & ~we_i & (reg_sel == REG_DATA) & rx_empty;
    assign ctrl_wr = commit & we_i & (reg_sel == REG_CTRL);
    assign flush   = ctrl_wr & data_i[CTRL_FLUSH];

    assign tx_valid_o = rst & ~tx_empty;
    assign tx_pop     = tx_valid_o & tx_ready_i;
    assign rx_ready_o = rst & ~rx_full & ~flush;
    assign rx_push    = rx_valid_i & rx_ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underflow <= 1'b0;
        end else if (flush) begin
            underflow <= 1'b0;
        end else if (uf_set) begin
            underflow <= 1'b1;
        end
    end

`ifdef RIB_MBOX_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= data_i[CTRL_IRQ_EN];
            end
            irq_q <= irq_en & (~rx_empty | underflow);
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    // ---------------- Read path ----------------
    always_comb begin
        status = '0;
        status[ST_RX_CNT_LSB +: CNT_W] = rx_count;
        status[ST_TX_CNT_LSB +: CNT_W] = tx_count;
        status[ST_RX_EMPTY]            = rx_empty;
        status[ST_TX_FULL]             = tx_full;
        status[ST_UNDERFLOW]           = underflow;
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_DATA:   rd_word = rx_empty ? '0 : rx_head;
            REG_STATUS: rd_word = status;
            REG_CTRL:   rd_word[CTRL_IRQ_EN] = irq_en;
            REG_RSVD:   rd_word = '0;
            default:    rd_word = '0;
        endcase
    end

    assign data_o = (commit && !we_i) ? rd_word : '0;

    // ---------------- FIFOs ----------------
    rib_mbox_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (data_i),
        .pop   (tx_pop),
        .flush (flush),
        .rdata (tx_data_o),
        .count (tx_count),
        .empty (tx_empty),
        .full  (tx_full)
    );

    rib_mbox_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (rx_data_i),
        .pop   (rx_pop),
        .flush (flush),
        .rdata (rx_head),
        .count (rx_count),
        .empty (rx_empty),
        .full  (rx_full)
    );

endmodule

// File: tb/tb_rib_mbox.sv
// Directed bench for rib_mbox with DEPTH=8, WAIT_CYCLES=2.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_rib_mbox;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        hold_o;
    logic [31:0] tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [31:0] rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;

    rib_mbox #(
        .DEPTH       (8),
        .WAIT_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .hold_o     (hold_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .irq_o      (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // One bus access started just after a rising edge; returns just after the completing edge.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int nhold);
        logic done;
        req_i  = 1'b1;
        we_i   = w;
        addr_i = a;
        data_i = d;
        nhold  = 0;
        rd     = '0;
        done   = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (hold_o) begin
                nhold++;
            end else begin
                rd   = data_o;
                done = 1'b1;
            end
        end
        chk("access_timeout", {31'b0, done}, 32'd1);
        @(posedge clk);
        #1;
        req_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = '0;
        data_i = '0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
        int nh;
        access(1'b0, a, 32'h0, v, nh);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        int nh;
        access(1'b1, a, d, v, nh);
    endtask

    initial begin
        logic [31:0] v;
        int          nh;
        int          cnt;

        // ---------- reset: outputs quiet even with activity on the inputs ----------
        rst        = 1'b0;
        req_i      = 1'b1;
        we_i       = 1'b0;
        addr_i     = 32'h0;
        data_i     = 32'h0;
        tx_ready_i = 1'b0;
        rx_data_i  = 32'h0;
        rx_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_hold", {31'b0, hold_o}, 32'd0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
        chk("rst_rx_ready", {31'b0, rx_ready_o}, 32'd0);
        chk("rst_irq", {31'b0, irq_o}, 32'd0);
        req_i      = 1'b0;
        rx_valid_i = 1'b0;
        sync();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_rx_ready", {31'b0, rx_ready_o}, 32'd1);
        chk("post_rst_hold", {31'b0, hold_o}, 32'd0);
        sync();

        // ---------- write DATA with two wait states ----------
        access(1'b1, 32'h0, 32'hDEADBEEF, v, nh);
        chk("wr_hold_cycles", nh, 32'd2);
        chk("wr_data_o_zero", v, 32'h0);
        @(negedge clk);
        chk("tx_valid_after_wr", {31'b0, tx_valid_o}, 32'd1);
        chk("tx_data_after_wr", tx_data_o, 32'hDEADBEEF);
        sync();
        rd_reg(32'h4, v);
        chk("status_tx1", v, 32'h0000_0420);

        // drain the single TX word
        tx_ready_i = 1'b1;
        sync();
        tx_ready_i = 1'b0;
        @(negedge clk);
        chk("tx_drained", {31'b0, tx_valid_o}, 32'd0);
        sync();

        // ---------- fill TX, then a 9th write stalls until a pop ----------
        for (int i = 0; i < 8; i++) begin
            wr_reg(32'h0, 32'hA0 + i);
        end
        req_i  = 1'b1;
        we_i   = 1'b1;
        addr_i = 32'h0;
        data_i = 32'h99;
        cnt    = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (hold_o) cnt++;
        end
        chk("full_hold_cycles", cnt, 32'd5);
        sync();
        tx_ready_i = 1'b1;
        @(negedge clk);
        chk("full_hold_pop_cycle", {31'b0, hold_o}, 32'd1);
        sync();
        tx_ready_i = 1'b0;
        @(negedge clk);
        chk("full_release", {31'b0, hold_o}, 32'd0);
        sync();
        req_i  = 1'b0;
        we_i   = 1'b0;
        data_i = 32'h0;
        chk("tx_head_after_pop", tx_data_o, 32'hA1);
        rd_reg(32'h4, v);
        chk("status_tx_full8", v, 32'h0000_0D00);

        // ---------- empty RX read, then flush ----------
        rd_reg(32'h0, v);
        chk("rx_empty_read", v, 32'h0);
        rd_reg(32'h4, v);
        chk("status_underflow", v, 32'h0000_1D00);
        wr_reg(32'h8, 32'h1);
        rd_reg(32'h4, v);
        chk("status_after_flush", v, 32'h0000_0400);
        chk("tx_valid_after_flush", {31'b0, tx_valid_o}, 32'd0);
        rd_reg(32'h8, v);
        chk("ctrl_flush_reads0", v, 32'h0);

        // ---------- RX stream into bus reads ----------
        rx_valid_i = 1'b1;
        rx_data_i  = 32'h11;
        sync();
        rx_data_i  = 32'h22;
        sync();
        rx_valid_i = 1'b0;
        rd_reg(32'h4, v);
        chk("rx_count2", v, 32'h0000_0002);
        rd_reg(32'h0, v);
        chk("rx_read_11", v, 32'h11);
        rd_reg(32'h4, v);
        chk("rx_count1", v, 32'h0000_0001);
        rd_reg(32'h0, v);
        chk("rx_read_22", v, 32'h22);
        rd_reg(32'h4, v);
        chk("rx_count0", v, 32'h0000_0400);

        // ---------- push and pop RX on the same edge ----------
        rx_valid_i = 1'b1;
        rx_data_i  = 32'h33;
        sync();
        rx_data_i  = 32'h44;
        access(1'b0, 32'h0, 32'h0, v, nh);
        rx_valid_i = 1'b0;
        chk("rx_read_33", v, 32'h33);
        rd_reg(32'h4, v);
        chk("rx_count_pushpop", v, 32'h0000_0003);
        wr_reg(32'h8, 32'h1);

        // ---------- reserved offset and address aliasing ----------
        wr_reg(32'hC, 32'hFFFF_FFFF);
        rd_reg(32'hC, v);
        chk("rsvd_read", v, 32'h0);
        rd_reg(32'h14, v);
        chk("status_alias", v, 32'h0000_0400);

        // ---------- interrupt ----------
        wr_reg(32'h8, 32'h2);
        rd_reg(32'h8, v);
`ifdef RIB_MBOX_IRQ_EN
        chk("ctrl_irq_en", v, 32'h2);
`else
        chk("ctrl_irq_en", v, 32'h0);
`endif
        chk("irq_idle", {31'b0, irq_o}, 32'd0);
        rx_valid_i = 1'b1;
        rx_data_i  = 32'h55;
        sync();
        rx_valid_i = 1'b0;
        @(negedge clk);
        chk("irq_same_cycle", {31'b0, irq_o}, 32'd0);
        @(negedge clk);
`ifdef RIB_MBOX_IRQ_EN
        chk("irq_one_later", {31'b0, irq_o}, 32'd1);
`else
        chk("irq_one_later", {31'b0, irq_o}, 32'd0);
`endif
        sync();

        // ---------- reset during WAIT ----------
        req_i  = 1'b1;
        we_i   = 1'b1;
        addr_i = 32'h0;
        data_i = 32'h66;
        @(negedge clk);
        chk("wait_hold_pre_rst", {31'b0, hold_o}, 32'd1);
        sync();
        rst = 1'b0;
        #1;
        chk("rst_in_wait_hold", {31'b0, hold_o}, 32'd0);
        chk("rst_in_wait_irq", {31'b0, irq_o}, 32'd0);
        req_i  = 1'b0;
        we_i   = 1'b0;
        data_i = 32'h0;
        sync();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_no_push", {31'b0, tx_valid_o}, 32'd0);
        sync();
        rd_reg(32'h4, v);
        chk("status_after_rst", v, 32'h0000_0400);
        rd_reg(32'h8, v);
        chk("ctrl_after_rst", v, 32'h0);

        // ---------- request dropped mid-access ----------
        req_i  = 1'b1;
        we_i   = 1'b1;
        addr_i = 32'h0;
        data_i = 32'h77;
        @(negedge clk);
        sync();
        req_i = 1'b0;
        @(negedge clk);
        chk("abandon_hold", {31'b0, hold_o}, 32'd0);
        sync();
        we_i   = 1'b0;
        data_i = 32'h0;
        sync();
        rd_reg(32'h4, v);
        chk("abandon_no_push", v, 32'h0000_0400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
